// File: rtl/amdc_ad4011_emulator_if.sv
// Signal bundle between the eddy-current SPI master and the AD4011 pair emulator.
// The master drives CNV/SCLK and the sample values; the emulator answers with serial data and status.
interface amdc_ad4011_emulator_if #(
    parameter int DATA_WIDTH = 18
);
    logic                  cnv;
    logic                  sclk;
    logic [DATA_WIDTH-1:0] sample_x;
    logic [DATA_WIDTH-1:0] sample_y;
    logic                  clr_err;
    logic                  miso_x;
    logic                  miso_y;
    logic                  busy;
    logic                  frame_done;
    logic [15:0]           frame_cnt;
    logic                  err_early;
    logic                  err_sclk;
    logic                  err_abort;

    modport master (
        output cnv, sclk, sample_x, sample_y, clr_err,
        input  miso_x, miso_y, busy, frame_done, frame_cnt, err_early, err_sclk, err_abort
    );

    modport slave (
        input  cnv, sclk, sample_x, sample_y, clr_err,
        output miso_x, miso_y, busy, frame_done, frame_cnt, err_early, err_sclk, err_abort
    );
endinterface

// File: rtl/amdc_ad4011_emulator.sv
// Responder-side model of the AD4011 ADC pair: answers the CNV/SCLK sequence with two
// serialized samples and flags CNV/SCLK protocol timing violations.
module amdc_ad4011_emulator #(
    parameter int DATA_WIDTH  = 18,
    parameter int CONV_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    amdc_ad4011_emulator_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT
    } state_t;

    localparam logic [7:0] CONV_MAX = 8'(CONV_CYCLES);
    localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH - 1);

    logic [2:0]            cnv_sync;
    logic [2:0]            sclk_sync;
    logic                  cnv_rise;
    logic                  cnv_fall;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  sclk_edge;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shadow_x;
    logic [DATA_WIDTH-1:0] shadow_x_next;
    logic [DATA_WIDTH-1:0] shadow_y;
    logic [DATA_WIDTH-1:0] shadow_y_next;
    logic [7:0]            conv_cnt;
    logic [7:0]            conv_cnt_next;
    logic [4:0]            bit_cnt;
    logic [4:0]            bit_cnt_next;
    logic [15:0]           frame_cnt;
    logic                  frame_done;
    logic                  frame_end;
    logic                  err_early;
    logic                  err_sclk;
    logic                  err_abort;
    logic                  set_early;
    logic                  set_sclk;
    logic                  set_abort;

    // Bit 0 and 1 form the metastability synchronizer, bit 2 is the delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnv_sync  <= '0;
            sclk_sync <= '0;
        end else begin
            cnv_sync  <= {cnv_sync[1:0], bus.cnv};
            sclk_sync <= {sclk_sync[1:0], bus.sclk};
        end
    end

    assign cnv_rise  = cnv_sync[1] & ~cnv_sync[2];
    assign cnv_fall  = ~cnv_sync[1] & cnv_sync[2];
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign sclk_edge = sclk_rise | sclk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shadow_x <= '0;
            shadow_y <= '0;
            conv_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_next;
            shadow_x <= shadow_x_next;
            shadow_y <= shadow_y_next;
            conv_cnt <= conv_cnt_next;
            bit_cnt  <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        shadow_x_next = shadow_x;
        shadow_y_next = shadow_y;
        conv_cnt_next = conv_cnt;
        bit_cnt_next  = bit_cnt;
        frame_end     = 1'b0;
        set_early     = 1'b0;
        set_sclk      = 1'b0;
        set_abort     = 1'b0;

        unique case (state)
            IDLE: begin
                if (cnv_rise) begin
                    shadow_x_next = bus.sample_x;
                    shadow_y_next = bus.sample_y;
                    conv_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = CONV;
                end
            end

            CONV: begin
                if (conv_cnt < CONV_MAX) begin
                    conv_cnt_next = conv_cnt + 8'd1;
                end
                set_sclk = sclk_edge;
                // The rise-detect cycle was already one CNV-high cycle, hence the +1.
                if (cnv_fall) begin
                    set_early  = (conv_cnt + 8'd1) < CONV_MAX;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (cnv_rise) begin
                    set_abort     = 1'b1;
                    shadow_x_next = bus.sample_x;
                    shadow_y_next = bus.sample_y;
                    conv_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = CONV;
                end else begin
                    if (sclk_rise) begin
                        shadow_x_next = {shadow_x[DATA_WIDTH-2:0], 1'b0};
                        shadow_y_next = {shadow_y[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (sclk_fall) begin
                        bit_cnt_next = bit_cnt + 5'd1;
                        if (bit_cnt == LAST_BIT) begin
                            frame_end  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sticky error flags: a set in the same cycle as clr_err survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_early  <= 1'b0;
            err_sclk   <= 1'b0;
            err_abort  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            err_early  <= (err_early & ~bus.clr_err) | set_early;
            err_sclk   <= (err_sclk  & ~bus.clr_err) | set_sclk;
            err_abort  <= (err_abort & ~bus.clr_err) | set_abort;
            frame_done <= frame_end;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign bus.miso_x     = (state == SHIFT) & shadow_x[DATA_WIDTH-1];
    assign bus.miso_y     = (state == SHIFT) & shadow_y[DATA_WIDTH-1];
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = frame_done;
    assign bus.frame_cnt  = frame_cnt;
    assign bus.err_early  = err_early;
    assign bus.err_sclk   = err_sclk;
    assign bus.err_abort  = err_abort;
endmodule

// File: tb/tb_amdc_ad4011_emulator.sv
// Bench for the AD4011 emulator: acts as the SPI master, captures the serial words and compares
// the status outputs against a frame-level model on every settled cycle.
module tb_amdc_ad4011_emulator;
    localparam int DATA_WIDTH  = 18;
    localparam int CONV_CYCLES = 64;
    localparam int SETTLE      = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    int  exp_frame_cnt  = 0;
    int  exp_done_total = 0;
    int  done_seen      = 0;
    int  settle         = SETTLE;
    bit  exp_early, exp_sclk, exp_abort, exp_busy, in_shift, compare_on;
    logic [DATA_WIDTH-1:0] latched_x, latched_y, cap_x, cap_y;
    logic [DATA_WIDTH-1:0] b2b_vals [3] = '{18'h3FFFF, 18'h00000, 18'h20001};

    amdc_ad4011_emulator_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    amdc_ad4011_emulator #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CONV_CYCLES (CONV_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Outputs lag the pins by a few clocks; comparisons resume once that window has passed.
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) done_seen++;
        if (settle > 0) begin
            settle--;
        end else if (compare_on) begin
            check_output("frame_cnt", 32'(bus.frame_cnt), exp_frame_cnt & 32'hFFFF);
            check_output("frame_done_count", done_seen, exp_done_total);
            check_output("frame_done_idle", 32'(bus.frame_done), 32'd0);
            check_output("busy", 32'(bus.busy), 32'(exp_busy));
            check_output("err_early", 32'(bus.err_early), 32'(exp_early));
            check_output("err_sclk", 32'(bus.err_sclk), 32'(exp_sclk));
            check_output("err_abort", 32'(bus.err_abort), 32'(exp_abort));
            if (!exp_busy) begin
                check_output("miso_x_idle", 32'(bus.miso_x), 32'd0);
                check_output("miso_y_idle", 32'(bus.miso_y), 32'd0);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.cnv       = 1'b0;
        bus.sclk      = 1'b0;
        bus.clr_err   = 1'b0;
        exp_frame_cnt = 0;
        exp_early     = 1'b0;
        exp_sclk      = 1'b0;
        exp_abort     = 1'b0;
        exp_busy      = 1'b0;
        in_shift      = 1'b0;
        settle        = SETTLE;
    endtask

    task automatic release_reset();
        wait_cycles(3);
        rst_n  = 1'b1;
        settle = SETTLE;
        wait_cycles(SETTLE);
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, "_miso_x"}, 32'(bus.miso_x), 32'd0);
        check_output({tag, "_miso_y"}, 32'(bus.miso_y), 32'd0);
        check_output({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_output({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        check_output({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
        check_output({tag, "_err_early"}, 32'(bus.err_early), 32'd0);
        check_output({tag, "_err_sclk"}, 32'(bus.err_sclk), 32'd0);
        check_output({tag, "_err_abort"}, 32'(bus.err_abort), 32'd0);
    endtask

    task automatic raise_cnv(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y);
        bus.sample_x = x;
        bus.sample_y = y;
        bus.cnv      = 1'b1;
        if (in_shift) exp_abort = 1'b1;
        in_shift  = 1'b0;
        latched_x = x;
        latched_y = y;
        exp_busy  = 1'b1;
        settle    = SETTLE;
    endtask

    task automatic hold_cnv(input int len, input int sclk_edges);
        int edges_left;
        edges_left = sclk_edges;
        for (int c = 0; c < len; c++) begin
            if (c == 4) begin
                bus.sample_x = DATA_WIDTH'($urandom);
                bus.sample_y = DATA_WIDTH'($urandom);
            end
            if (edges_left > 0 && c >= 8 && ((c - 8) % 4) == 0) begin
                bus.sclk = ~bus.sclk;
                edges_left--;
                exp_sclk = 1'b1;
                settle   = SETTLE;
            end
            wait_cycles(1);
        end
        bus.cnv = 1'b0;
        if (len < CONV_CYCLES) exp_early = 1'b1;
        in_shift = 1'b1;
        settle   = SETTLE;
    endtask

    task automatic shift_bits(input int nbits, input int half);
        cap_x = '0;
        cap_y = '0;
        for (int i = 0; i < nbits; i++) begin
            wait_cycles(half);
            cap_x    = {cap_x[DATA_WIDTH-2:0], bus.miso_x};
            cap_y    = {cap_y[DATA_WIDTH-2:0], bus.miso_y};
            bus.sclk = 1'b1;
            wait_cycles(half);
            bus.sclk     = 1'b0;
            bus.sample_x = DATA_WIDTH'($urandom);
            bus.sample_y = DATA_WIDTH'($urandom);
        end
        if (nbits == DATA_WIDTH) begin
            exp_frame_cnt++;
            exp_done_total++;
            exp_busy = 1'b0;
            in_shift = 1'b0;
            settle   = SETTLE;
        end
    endtask

    task automatic full_frame(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y,
                              input int len, input int edges, input int half, input string tag);
        raise_cnv(x, y);
        hold_cnv(len, edges);
        shift_bits(DATA_WIDTH, half);
        check_output({tag, "_word_x"}, 32'(cap_x), 32'(latched_x));
        check_output({tag, "_word_y"}, 32'(cap_y), 32'(latched_y));
        wait_cycles(SETTLE);
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        exp_early   = 1'b0;
        exp_sclk    = 1'b0;
        exp_abort   = 1'b0;
        settle      = SETTLE;
        wait_cycles(1);
        bus.clr_err = 1'b0;
        wait_cycles(SETTLE);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.sample_x = '0;
        bus.sample_y = '0;
        apply_reset();
        wait_cycles(2);
        check_zero("in_reset");
        release_reset();
        compare_on = 1'b1;
        check_zero("after_reset");

        $display("[TB] basic frame");
        full_frame(18'h2AAAA, 18'h15555, 64, 0, 11, "basic");
        check_output("basic_lit_x", 32'(cap_x), 32'h2AAAA);
        check_output("basic_lit_y", 32'(cap_y), 32'h15555);
        check_output("basic_lit_cnt", 32'(bus.frame_cnt), 32'd1);
        check_output("basic_lit_errs", {29'd0, bus.err_early, bus.err_sclk, bus.err_abort}, 32'd0);

        $display("[TB] back-to-back frames");
        apply_reset();
        release_reset();
        for (int i = 0; i < 3; i++) begin
            full_frame(b2b_vals[i], DATA_WIDTH'($urandom), 64, 0, 11, "b2b");
            check_output("b2b_lit_x", 32'(cap_x), 32'(b2b_vals[i]));
        end
        check_output("b2b_lit_cnt", 32'(bus.frame_cnt), 32'd3);

        $display("[TB] early cnv fall");
        full_frame(18'h12345, DATA_WIDTH'($urandom), 30, 0, 8, "early");
        check_output("early_lit_x", 32'(cap_x), 32'h12345);
        check_output("early_lit_flag", 32'(bus.err_early), 32'd1);
        pulse_clr();
        check_output("early_lit_clr", 32'(bus.err_early), 32'd0);

        $display("[TB] sclk during conversion");
        full_frame(18'h0F00F, 18'h30C0C, 64, 4, 9, "sclk_conv");
        check_output("sclk_lit_flag", 32'(bus.err_sclk), 32'd1);
        check_output("sclk_lit_x", 32'(cap_x), 32'h0F00F);
        pulse_clr();

        $display("[TB] abort mid-frame");
        raise_cnv(18'h11111, 18'h22222);
        hold_cnv(64, 0);
        shift_bits(9, 10);
        wait_cycles(SETTLE);
        full_frame(18'h1F0F0, 18'h0A5A5, 64, 0, 10, "post_abort");
        check_output("abort_lit_flag", 32'(bus.err_abort), 32'd1);
        check_output("abort_lit_x", 32'(cap_x), 32'h1F0F0);
        check_output("abort_lit_y", 32'(cap_y), 32'h0A5A5);
        check_output("abort_lit_cnt", 32'(bus.frame_cnt), 32'd6);

        $display("[TB] reset mid-shift");
        raise_cnv(18'h3ABCD, 18'h01234);
        hold_cnv(64, 0);
        shift_bits(5, 10);
        apply_reset();
        #1;
        check_zero("mid_reset");
        release_reset();
        full_frame(18'h0BEEF, 18'h3C3C3, 64, 0, 10, "after_mid_reset");
        check_output("mid_reset_lit_cnt", 32'(bus.frame_cnt), 32'd1);
        check_output("mid_reset_lit_x", 32'(cap_x), 32'h0BEEF);

        $display("[TB] randomized frames");
        for (int n = 0; n < 10; n++) begin
            int len;
            int edges;
            int half;
            len   = $urandom_range(CONV_CYCLES + 10, CONV_CYCLES - 6);
            edges = $urandom_range(1, 0) * 2;
            half  = $urandom_range(12, 6);
            if ($urandom_range(3, 0) == 0) pulse_clr();
            full_frame(DATA_WIDTH'($urandom), DATA_WIDTH'($urandom), len, edges, half, "rand");
        end

        wait_cycles(SETTLE + 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
